operand2_shift_sequencer: RTL

Multi-cycle sequencer that produces the ARM data-processing second operand (Val2) and shifter carry-out. It computes the result iteratively, STEP bit positions per cycle, instead of with a full barrel shifter. It also supports register-specified shift amounts (Rs). It sits in EXE beside the ALU; busy is fed to the hazard unit to stall the pipeline while a shift is in progress.

---
 rtl/operand2_shift_sequencer_pkg.sv | 43 ++++
 rtl/operand2_shift_sequencer_if.sv | 30 +++
 rtl/operand2_shift_sequencer_shift_step.sv | 59 +++++
 rtl/operand2_shift_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/operand2_shift_sequencer_pkg.sv
// Shared definitions for the operand-2 shift sequencer.
// Contents:
//   SHIFT_LSL/LSR/ASR/ROR  2-bit shift operation codes (instruction bits [6:5])
//   state_t                sequencer states IDLE / RUN / DONE
//   COUNT_W                width of the remaining-shift counter (0..33)
//   clamp_count()          maps a raw shift amount to the number of steps to run
package operand2_shift_sequencer_pkg;

    localparam int COUNT_W = 6;

    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Linear shifts saturate at 33: one step past 32 flushes the last
    // shifted-out bit so LSL/LSR give carry 0 and ASR keeps the sign.
    // Rotates only care about n mod 32, but a non-zero multiple of 32 still
    // runs a full turn so the carry becomes bit 31.
    function automatic logic [COUNT_W-1:0] clamp_count(input logic [1:0] op,
                                                       input logic [7:0] n);
        logic [COUNT_W-1:0] result;
        if (op == SHIFT_ROR) begin
            if ((n != 8'd0) && (n[4:0] == 5'd0)) begin
                result = 6'd32;
            end else begin
                result = {1'b0, n[4:0]};
            end
        end else if (n > 8'd33) begin
            result = 6'd33;
        end else begin
            result = n[5:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/operand2_shift_sequencer_if.sv
// Handshake and operand bundle for the operand-2 shift sequencer.
//   master: pipeline side (drives start/flush/operands, observes results)
//   slave : sequencer side
// Signals: start, flush, val_rm[31:0], rs_val[31:0], shift_operand[11:0],
//          imm, mem, carry_in  -> sequencer
//          busy, done, val2[31:0], carry_out  <- sequencer
interface operand2_shift_sequencer_if;
    logic        start;
    logic        flush;
    logic [31:0] val_rm;
    logic [31:0] rs_val;
    logic [11:0] shift_operand;
    logic        imm;
    logic        mem;
    logic        carry_in;
    logic        busy;
    logic        done;
    logic [31:0] val2;
    logic        carry_out;

    modport master (
        output start, flush, val_rm, rs_val, shift_operand, imm, mem, carry_in,
        input  busy, done, val2, carry_out
    );

    modport slave (
        input  start, flush, val_rm, rs_val, shift_operand, imm, mem, carry_in,
        output busy, done, val2, carry_out
    );
endinterface

// File: rtl/operand2_shift_sequencer_shift_step.sv
// shift_step: combinational single step of the sequencer datapath.
// Shifts/rotates a 32-bit word by k positions (0..STEP) and returns the last
// bit shifted out as carry. k=0 passes work and carry_in through unchanged.
// Ports:
//   work[31:0]      current working value
//   op[1:0]         LSL / LSR / ASR / ROR
//   k[K_W-1:0]      positions to move this step
//   carry_in        carry from the previous step
//   next_work[31:0] shifted value
//   carry_out       last bit shifted out
module shift_step
    import operand2_shift_sequencer_pkg::*;
#(
    parameter int STEP = 1,
    parameter int K_W  = $clog2(STEP + 1)
) (
    input  logic [31:0]    work,
    input  logic [1:0]     op,
    input  logic [K_W-1:0] k,
    input  logic           carry_in,
    output logic [31:0]    next_work,
    output logic           carry_out
);

    // {carry, value} after shifting w by a fixed amount (1..STEP)
    function automatic logic [32:0] shift_by(input logic [31:0] w,
                                             input logic [1:0]  sop,
                                             input int          amt);
        logic [32:0] r;
        case (sop)
            SHIFT_LSR: r = {w[5'(amt - 1)], w >> amt};
            SHIFT_ASR: r = {w[5'(amt - 1)], 32'($signed(w) >>> amt)};
            SHIFT_ROR: r = {w[5'(amt - 1)], (w >> amt) | (w << (32 - amt))};
            default:   r = {w[5'(32 - amt)], w << amt};
        endcase
        return r;
    endfunction

    // One small fixed-amount shifter per legal step size, then a k-select.
    logic [32:0] cand [1:STEP];

    genvar gi;
    generate
        for (gi = 1; gi <= STEP; gi++) begin : g_amt
            assign cand[gi] = shift_by(work, op, gi);
        end
    endgenerate

    always_comb begin
        next_work = work;
        carry_out = carry_in;
        for (int i = 1; i <= STEP; i++) begin
            if (k == K_W'(i)) begin
                {carry_out, next_work} = cand[i];
            end
        end
    end

endmodule

// File: rtl/operand2_shift_sequencer.sv
// operand2_shift_sequencer: multi-cycle generator of the ARM data-processing
// second operand (val2) and shifter carry-out, moving STEP bit positions per
// RUN cycle instead of using a full barrel shifter.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  operand2_shift_sequencer_if.slave
//        start/flush/val_rm/rs_val/shift_operand/imm/mem/carry_in in,
//        busy (high in RUN), done (one-cycle pulse), val2, carry_out out
// Parameter STEP: positions per RUN cycle, one of 1, 2, 4, 8.
module operand2_shift_sequencer #(
    parameter int STEP = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    operand2_shift_sequencer_if.slave     bus
);
    import operand2_shift_sequencer_pkg::*;

    localparam int K_W = $clog2(STEP + 1);

    state_t             state_reg, state_next;
    logic [COUNT_W-1:0] count_reg;
    logic [COUNT_W-1:0] count_dec;
    logic [31:0]        work_reg;
    logic               carry_reg;
    logic [1:0]         op_reg;
    logic [31:0]        val2_reg;
    logic               carry_out_reg;
    logic               accept;

    logic [7:0]         shift_n;
    logic [31:0]        load_work;
    logic [1:0]         load_op;
    logic [COUNT_W-1:0] load_count;

    logic [K_W-1:0]     k;
    logic [31:0]        step_work;
    logic               step_carry;

    // Only the low byte of Rs is a shift amount.
    logic unused_rs_hi;
    assign unused_rs_hi = ^bus.rs_val[31:8];

    // Operand decode: mem offsets pass through unshifted, immediates are an
    // 8-bit value rotated by twice the rotate field, otherwise Rm is shifted.
    always_comb begin
        shift_n    = bus.shift_operand[4] ? bus.rs_val[7:0]
                                          : {3'b000, bus.shift_operand[11:7]};
        load_work  = bus.val_rm;
        load_op    = bus.shift_operand[6:5];
        load_count = clamp_count(load_op, shift_n);
        if (bus.mem) begin
            load_work  = {20'b0, bus.shift_operand};
            load_op    = SHIFT_LSL;
            load_count = '0;
        end else if (bus.imm) begin
            load_work  = {24'b0, bus.shift_operand[7:0]};
            load_op    = SHIFT_ROR;
            load_count = {1'b0, bus.shift_operand[11:8], 1'b0};
        end
    end

    // k = min(count, STEP)
    always_comb begin
        if (count_reg > COUNT_W'(STEP)) begin
            k = K_W'(STEP);
        end else begin
            k = count_reg[K_W-1:0];
        end
    end

    assign count_dec = count_reg - COUNT_W'(k);

    shift_step #(
        .STEP (STEP),
        .K_W  (K_W)
    ) u_shift_step (
        .work      (work_reg),
        .op        (op_reg),
        .k         (k),
        .carry_in  (carry_reg),
        .next_work (step_work),
        .carry_out (step_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // flush beats start; start is only looked at in IDLE/DONE.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                state_next = ST_IDLE;
                if (bus.start && !bus.flush) begin
                    accept     = 1'b1;
                    state_next = (load_count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.flush) begin
                    state_next = ST_IDLE;
                end else if (count_dec == '0) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The published result only changes on completion, so an aborted shift
    // leaves the previous val2/carry_out visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_reg      <= '0;
            count_reg     <= '0;
            carry_reg     <= 1'b0;
            op_reg        <= SHIFT_LSL;
            val2_reg      <= '0;
            carry_out_reg <= 1'b0;
        end else if (accept) begin
            work_reg  <= load_work;
            count_reg <= load_count;
            carry_reg <= bus.carry_in;
            op_reg    <= load_op;
            if (load_count == '0) begin
                val2_reg      <= load_work;
                carry_out_reg <= bus.carry_in;
            end
        end else if ((state_reg == ST_RUN) && !bus.flush) begin
            work_reg  <= step_work;
            carry_reg <= step_carry;
            count_reg <= count_dec;
            if (count_dec == '0) begin
                val2_reg      <= step_work;
                carry_out_reg <= step_carry;
            end
        end
    end

    assign bus.busy      = (state_reg == ST_RUN);
    assign bus.done      = (state_reg == ST_DONE);
    assign bus.val2      = val2_reg;
    assign bus.carry_out = carry_out_reg;

endmodule
